// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared WIDTH-bit barrel shifter.
// Define SHIFT_ARBITER_ROTATE_EN to make op 11 a rotate right; otherwise op 11 is a logical right shift.
module shift_arbiter #(
   parameter int WIDTH = 4,
   parameter int SH_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid0,
   output logic             ready0,
   input  logic [WIDTH-1:0] din0,
   input  logic [SH_W-1:0]  sh_amt0,
   input  logic [1:0]       op0,
   input  logic             valid1,
   output logic             ready1,
   input  logic [WIDTH-1:0] din1,
   input  logic [SH_W-1:0]  sh_amt1,
   input  logic [1:0]       op1,
   output logic [WIDTH-1:0] dout,
   output logic             done0,
   output logic             done1,
   output logic             busy
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           r_state;
   logic             r_last;
   logic             r_id;
   logic [WIDTH-1:0] r_din;
   logic [SH_W-1:0]  r_sh;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_dout;
   logic             r_done0;
   logic             r_done1;
   logic             r_busy;

   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic [WIDTH-1:0] w_result;

   // r_last names the requester served most recently; the other one wins a tie.
   assign w_grant0 = valid0 && (!valid1 || r_last);
   assign w_grant1 = valid1 && (!valid0 || !r_last);
   assign ready0   = !rst && (r_state == IDLE) && w_grant0;
   assign ready1   = !rst && (r_state == IDLE) && w_grant1;
   assign w_accept = ready0 || ready1;

   assign dout  = r_dout;
   assign done0 = r_done0;
   assign done1 = r_done1;
   assign busy  = r_busy;

`ifdef SHIFT_ARBITER_ROTATE_EN
   logic [2*WIDTH-1:0] w_rot;
   assign w_rot = {r_din, r_din} >> r_sh;
`endif

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves w_result unassigned (no latch).
      w_result = r_din;
      case (r_op)
         2'b00:   w_result = r_din << r_sh;
         2'b01:   w_result = r_din >> r_sh;
         2'b10:   w_result = $signed(r_din) >>> r_sh;
`ifdef SHIFT_ARBITER_ROTATE_EN
         default: w_result = w_rot[WIDTH-1:0];
`else
         default: w_result = r_din >> r_sh;
`endif
      endcase
   end

   // NOTE: captured operands carry no reset; they are only consumed in EXEC, which always follows a capture.
   always_ff @(posedge clk) begin
      if (r_state == IDLE && w_accept) begin
         r_id  <= ready1;
         r_din <= ready1 ? din1    : din0;
         r_sh  <= ready1 ? sh_amt1 : sh_amt0;
         r_op  <= ready1 ? op1     : op0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_dout  <= '0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_last  <= ready1;
                  r_state <= EXEC;
                  r_busy  <= 1'b1;
               end
            end
            EXEC: begin
               r_dout  <= w_result;
               r_done0 <= !r_id;
               r_done1 <= r_id;
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: a rule-level reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_shift_arbiter;

   localparam int WIDTH = 4;
   localparam int SH_W  = 2;
`ifdef SHIFT_ARBITER_ROTATE_EN
   localparam logic [3:0] ROT_EXP = 4'b1001;
`else
   localparam logic [3:0] ROT_EXP = 4'b0001;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             valid0, valid1;
   logic             ready0, ready1;
   logic [WIDTH-1:0] din0, din1;
   logic [SH_W-1:0]  sh_amt0, sh_amt1;
   logic [1:0]       op0, op1;
   logic [WIDTH-1:0] dout;
   logic             done0, done1, busy;

   int n_cmp = 0;
   int n_err = 0;

   shift_arbiter #(.WIDTH(WIDTH), .SH_W(SH_W)) dut (
      .clk(clk), .rst(rst),
      .valid0(valid0), .ready0(ready0), .din0(din0), .sh_amt0(sh_amt0), .op0(op0),
      .valid1(valid1), .ready1(ready1), .din1(din1), .sh_amt1(sh_amt1), .op1(op1),
      .dout(dout), .done0(done0), .done1(done1), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Bit-by-bit definition of each shift type.
   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int s,
                                                  input logic [1:0] op);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         case (op)
            2'd0:    r[i] = (i >= s) ? d[i-s] : 1'b0;
            2'd1:    r[i] = (i + s < WIDTH) ? d[i+s] : 1'b0;
            2'd2:    r[i] = (i + s < WIDTH) ? d[i+s] : d[WIDTH-1];
`ifdef SHIFT_ARBITER_ROTATE_EN
            default: r[i] = d[(i + s) % WIDTH];
`else
            default: r[i] = (i + s < WIDTH) ? d[i+s] : 1'b0;
`endif
         endcase
      end
      return r;
   endfunction

   // Reference model: at most one operation in flight, result one edge after acceptance.
   logic             m_busy  = 1'b0;
   logic             m_id    = 1'b0;
   logic             m_last  = 1'b1;
   logic             m_done0 = 1'b0;
   logic             m_done1 = 1'b0;
   logic [WIDTH-1:0] m_res   = '0;
   logic [WIDTH-1:0] m_dout  = '0;
   logic             exp_r0, exp_r1;
   logic             cmp_en  = 1'b0;

   assign exp_r0 = !rst && !m_busy && valid0 && (!valid1 || m_last);
   assign exp_r1 = !rst && !m_busy && valid1 && (!valid0 || !m_last);

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_last <= 1'b1; m_dout <= '0; m_done0 <= 1'b0; m_done1 <= 1'b0;
      end else begin
         m_done0 <= m_busy && !m_id;
         m_done1 <= m_busy && m_id;
         if (m_busy) begin
            m_dout <= m_res;
            m_busy <= 1'b0;
         end else if (exp_r0) begin
            m_res <= ref_shift(din0, int'(sh_amt0), op0);
            m_id  <= 1'b0; m_last <= 1'b0; m_busy <= 1'b1;
         end else if (exp_r1) begin
            m_res <= ref_shift(din1, int'(sh_amt1), op1);
            m_id  <= 1'b1; m_last <= 1'b1; m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ready0", ready0, exp_r0);
         check("ready1", ready1, exp_r1);
         check("busy",   busy,   m_busy);
         check("done0",  done0,  m_done0);
         check("done1",  done1,  m_done1);
         check("dout",   dout,   m_dout);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input logic id);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (id ? ready1 : ready0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic id, input logic [3:0] d, input logic [1:0] s,
                         input logic [1:0] o, input logic [3:0] exp, input string name);
      if (id) begin valid1 = 1'b1; din1 = d; sh_amt1 = s; op1 = o; end
      else    begin valid0 = 1'b1; din0 = d; sh_amt0 = s; op0 = o; end
      wait_ready(id);
      tick();
      valid0 = 1'b0;
      valid1 = 1'b0;
      check({name, "_busy"}, busy, 1'b1);
      tick();
      check({name, "_dout"}, dout, exp);
      check({name, "_done"}, id ? done1 : done0, 1'b1);
   endtask

   logic [3:0] sweep_exp [0:2][0:3] = '{'{4'h8, 4'h0, 4'h0, 4'h0},
                                        '{4'h8, 4'h4, 4'h2, 4'h1},
                                        '{4'h8, 4'hC, 4'hE, 4'hF}};
   int g_id[$];
   int g_cyc[$];

   initial begin
      rst = 1'b1; valid0 = 1'b1; valid1 = 1'b1;
      din0 = '0; din1 = '0; sh_amt0 = '0; sh_amt1 = '0; op0 = '0; op1 = '0;
      tick(); tick();
      check("rst_ready0", ready0, 1'b0);
      check("rst_ready1", ready1, 1'b0);
      check("rst_dout",   dout,   4'h0);
      check("rst_busy",   busy,   1'b0);
      check("rst_done",   {done0, done1}, 2'b00);
      cmp_en = 1'b1;
      rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0;

      // Arithmetic right of 1011 by 1.
      run_op(1'b0, 4'b1011, 2'd1, 2'b10, 4'b1101, "first");

      for (int o = 0; o < 3; o++)
         for (int s = 0; s < 4; s++)
            run_op(1'b0, 4'b1000, 2'(s), 2'(o), sweep_exp[o][s], $sformatf("sweep_op%0d_sh%0d", o, s));
      run_op(1'b1, 4'b1000, 2'd0, 2'b11, 4'b1000, "op3_sh0");
      run_op(1'b0, 4'b0011, 2'd1, 2'b11, ROT_EXP, "op3_rot");

      // Contention from reset: grants must alternate starting with requester 0.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      valid0 = 1'b1; din0 = 4'b0110; sh_amt0 = 2'd1; op0 = 2'b00;
      valid1 = 1'b1; din1 = 4'b0110; sh_amt1 = 2'd1; op1 = 2'b01;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (ready0) begin g_id.push_back(0); g_cyc.push_back(c); end
         if (ready1) begin g_id.push_back(1); g_cyc.push_back(c); end
         if (done0) check("contend_dout0", dout, 4'b1100);
         if (done1) check("contend_dout1", dout, 4'b0011);
      end
      @(posedge clk); #1;
      valid0 = 1'b0; valid1 = 1'b0;
      check("contend_grants", g_id.size(), 4);
      for (int i = 0; i < g_id.size() && i < 4; i++) begin
         check($sformatf("contend_order%0d", i), g_id[i], i % 2);
         if (i > 0) check($sformatf("contend_gap%0d", i), g_cyc[i] - g_cyc[i-1], 2);
      end
      tick();

      // Requester 1 withdraws while requester 0 is served.
      valid0 = 1'b1; din0 = 4'b0001; sh_amt0 = 2'd2; op0 = 2'b00;
      valid1 = 1'b1; din1 = 4'b1010; sh_amt1 = 2'd1; op1 = 2'b00;
      @(negedge clk);
      check("wd_ready0", ready0, 1'b1);
      check("wd_ready1", ready1, 1'b0);
      tick();
      valid0 = 1'b0; valid1 = 1'b0;
      tick();
      check("wd_dout", dout, 4'b0100);
      tick(); tick();
      check("wd_no_done1", done1, 1'b0);
      check("wd_idle", busy, 1'b0);
      valid0 = 1'b1; valid1 = 1'b1;
      @(negedge clk);
      check("wd_next_ready1", ready1, 1'b1);
      check("wd_next_ready0", ready0, 1'b0);
      tick();
      valid0 = 1'b0; valid1 = 1'b0;
      tick();
      check("wd_next_dout", dout, 4'b0100);

      // Reset while requester 1's operation is executing.
      tick();
      valid1 = 1'b1; din1 = 4'b1111; sh_amt1 = 2'd0; op1 = 2'b00;
      wait_ready(1'b1);
      tick();
      valid1 = 1'b0;
      check("abort_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      check("abort_done1", done1, 1'b0);
      check("abort_dout",  dout,  4'h0);
      check("abort_busy0", busy,  1'b0);
      rst = 1'b0;
      valid0 = 1'b1; valid1 = 1'b1;
      @(negedge clk);
      check("abort_ready0", ready0, 1'b1);
      check("abort_ready1", ready1, 1'b0);
      tick();
      valid0 = 1'b0; valid1 = 1'b0;
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

- Shares one WIDTH-bit barrel shifter datapath between two requesters.
- Each requester has a valid/ready handshake.
- Grants are round-robin, and each accepted operation gets a registered result with a per-requester done pulse.
- Sits between the shift-issuing controllers and the shifter, so the shifter is instantiated once, not per client.

## Interface
Parameters:
- WIDTH, 4, data width; must be a power of two ≥ 4
- SH_W, 2, shift-amount width; must equal log2(WIDTH)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- valid0  input  1  requester 0 has an operation pending
- ready0  output  1  arbiter accepts requester 0 this cycle
- din0  input  WIDTH  requester 0 operand
- sh_amt0  input  SH_W  requester 0 shift amount
- op0  input  2  requester 0 shift type
- valid1 / ready1 / din1 / sh_amt1 / op1: same as above, for requester 1
- dout  output  WIDTH  registered shift result, shared by both requesters
- done0  output  1  one-cycle pulse: dout holds requester 0's result
- done1  output  1  one-cycle pulse: dout holds requester 1's result
- busy  output  1  high while in EXEC

## Operation
- op encoding:
  - 00: logical left, zero fill
  - 01: logical right, zero fill
  - 10: arithmetic right; vacated MSBs are copies of din[WIDTH-1]
  - 11: rotate right (see Configuration)
- Shift amount 0 returns the operand unchanged for every op. Result is always WIDTH bits; shifted-out bits are discarded.
- FSM has two states, IDLE and EXEC; reset state is IDLE.
- IDLE:
  - Winner is the valid requester. If both are valid, the winner is the one not served last.
  - Last-served pointer resets to 1, so requester 0 wins the first contention.
  - Only the winner's ready is high; ready is combinational from state, valid and pointer.
  - On valid&ready: capture din, sh_amt, op and the requester id; update pointer; go to EXEC.
- EXEC:
  - Both readys low; busy high.
  - Shift the captured operands; register the result into dout; pulse done of the captured id; return to IDLE.
- dout holds its last value until the next result. It is never cleared except by reset.
- Requesters must hold din/sh_amt/op stable while valid is high and ready is low. Dropping valid before acceptance withdraws the request with no side effects.
- A requester that keeps valid high after acceptance is treated as issuing a new request.

## Timing
- Reset values: ready0=ready1=0 while rst is high, dout=0, done0=done1=0, busy=0, pointer=1.
- Acceptance at edge T (valid&ready sampled high).
  - EXEC during cycle T→T+1; busy=1.
  - Edge T+1: dout updated, done high for exactly one cycle, FSM back in IDLE.
- Latency: one cycle from acceptance to result.
- Throughput: one operation every 2 cycles. A new acceptance may coincide with a done pulse, since IDLE and done share the cycle after T+1.
- done0 and done1 are never high together.
- Both valid in IDLE: exactly one ready is high. The loser's ready rises in the next IDLE cycle; no requester waits more than one operation.
- rst high during EXEC:
  - Operation aborted; no done pulse; dout=0; pointer=1.
  - State is IDLE on the edge after rst is deasserted.

## Configuration
- Macro: SHIFT_ARBITER_ROTATE_EN.
- Defined: op 11 rotates right by sh_amt; bits shifted out of the LSB re-enter at the MSB.
- Undefined: op 11 is identical to op 01 (logical right). No rotate logic is synthesised.

## Test plan
- Reset, then valid0 with din0=4'b1011, sh_amt0=1, op0=10 → ready0=1, busy=1 the next cycle, dout=4'b1101 with done0 one cycle after acceptance.
- valid0 and valid1 held high with identical timing → grant order 0,1,0,1; done0/done1 alternate; each result arrives 1 cycle after its acceptance; throughput is one op per 2 cycles.
- Amount sweep, din=4'b1000, every op, sh_amt 0..3:
  - op 00 → 1000, 0000, 0000, 0000
  - op 01 → 1000, 0100, 0010, 0001
  - op 10 → 1000, 1100, 1110, 1111
- din=4'b0011, sh_amt=1, op=11:
  - ROTATE_EN defined → dout=4'b1001
  - ROTATE_EN undefined → dout=4'b0001
- valid1 asserted, then dropped before ready1 (requester 0 being served) → no acceptance, no done1; pointer unchanged.
- rst pulsed during EXEC of a requester-1 op → no done1; dout=0; the next contention grants requester 0 first.
